// File: rtl/apb_cfg_initiator.sv
// APB requester that turns a buffered command stream into SETUP/ACCESS transfers, one response per command.
// Optional `APB_TIMEOUT_EN` abandons an ACCESS phase after TIMEOUT_CYCLES wait cycles and reports an error.
module apb_cfg_initiator #(
  parameter int ADDR_W         = 12,
  parameter int DATA_W         = 32,
  parameter int FIFO_DEPTH     = 4,
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic              cmd_write,
  input  logic [ADDR_W-1:0] cmd_addr,
  input  logic [DATA_W-1:0] cmd_wdata,
  output logic              rsp_valid,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              rsp_err,
  output logic              busy,
  output logic [ADDR_W-1:0] paddr,
  output logic              psel,
  output logic              penable,
  output logic              pwrite,
  output logic [DATA_W-1:0] pwdata,
  input  logic [DATA_W-1:0] prdata,
  input  logic              pready,
  input  logic              pslverr
);

  localparam int AW = $clog2(FIFO_DEPTH);

  typedef struct packed {
    logic              wr;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
  } cmd_t;

  typedef enum logic [1:0] {IDLE, SETUP, ACCESS} state_t;

  state_t            state_q, state_d;
  cmd_t              mem_q [FIFO_DEPTH];
  cmd_t              mem_d [FIFO_DEPTH];
  logic [AW:0]       wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [ADDR_W-1:0] paddr_q, paddr_d;
  logic              pwrite_q, pwrite_d;
  logic [DATA_W-1:0] pwdata_q, pwdata_d;
  logic              rsp_valid_q, rsp_valid_d;
  logic [DATA_W-1:0] rsp_rdata_q, rsp_rdata_d;
  logic              rsp_err_q, rsp_err_d;
  logic              full, empty, push, pop;
  cmd_t              head;

`ifdef APB_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  logic [TW-1:0] tmo_q, tmo_d;
`endif

  assign full  = (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]) && (wr_ptr_q[AW] != rd_ptr_q[AW]);
  assign empty = (wr_ptr_q == rd_ptr_q);
  // Ready is occupancy-only: a full FIFO refuses even when a pop frees a slot this cycle.
  assign push  = cmd_valid && !full;
  assign head  = mem_q[rd_ptr_q[AW-1:0]];

  always_comb begin
    state_d     = state_q;
    mem_d       = mem_q;
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    paddr_d     = paddr_q;
    pwrite_d    = pwrite_q;
    pwdata_d    = pwdata_q;
    rsp_valid_d = 1'b0;
    rsp_rdata_d = rsp_rdata_q;
    rsp_err_d   = rsp_err_q;
    pop         = 1'b0;
`ifdef APB_TIMEOUT_EN
    tmo_d       = '0;
`endif

    case (state_q)
      IDLE: begin
        if (!empty) begin
          pop     = 1'b1;
          state_d = SETUP;
        end
      end
      SETUP: state_d = ACCESS;
      ACCESS: begin
        if (pready) begin
          rsp_valid_d = 1'b1;
          rsp_rdata_d = pwrite_q ? '0 : prdata;
          rsp_err_d   = pslverr;
          if (!empty) begin
            pop     = 1'b1;
            state_d = SETUP;
          end else begin
            state_d = IDLE;
          end
        end
`ifdef APB_TIMEOUT_EN
        // Abandoning goes through IDLE so psel visibly drops before the next transfer.
        else if (tmo_q == TW'(TIMEOUT_CYCLES)) begin
          rsp_valid_d = 1'b1;
          rsp_rdata_d = '0;
          rsp_err_d   = 1'b1;
          state_d     = IDLE;
        end else begin
          tmo_d = tmo_q + 1'b1;
        end
`endif
      end
      default: state_d = IDLE;
    endcase

    if (pop) begin
      paddr_d  = head.addr;
      pwrite_d = head.wr;
      pwdata_d = head.wr ? head.wdata : '0;
      rd_ptr_d = rd_ptr_q + 1'b1;
    end

    if (push) begin
      mem_d[wr_ptr_q[AW-1:0]] = '{wr: cmd_write, addr: cmd_addr, wdata: cmd_wdata};
      wr_ptr_d = wr_ptr_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      paddr_q     <= '0;
      pwrite_q    <= 1'b0;
      pwdata_q    <= '0;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= '0;
      rsp_err_q   <= 1'b0;
      for (int i = 0; i < FIFO_DEPTH; i++) mem_q[i] <= '0;
`ifdef APB_TIMEOUT_EN
      tmo_q       <= '0;
`endif
    end else begin
      state_q     <= state_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      paddr_q     <= paddr_d;
      pwrite_q    <= pwrite_d;
      pwdata_q    <= pwdata_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_rdata_q <= rsp_rdata_d;
      rsp_err_q   <= rsp_err_d;
      for (int i = 0; i < FIFO_DEPTH; i++) mem_q[i] <= mem_d[i];
`ifdef APB_TIMEOUT_EN
      tmo_q       <= tmo_d;
`endif
    end
  end

  assign cmd_ready = !full;
  assign psel      = (state_q != IDLE);
  assign penable   = (state_q == ACCESS);
  assign paddr     = paddr_q;
  assign pwrite    = pwrite_q;
  assign pwdata    = pwdata_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_rdata = rsp_rdata_q;
  assign rsp_err   = rsp_err_q;
  assign busy      = !empty || (state_q != IDLE) || rsp_valid_q;

endmodule

// File: doc/apb_cfg_initiator.md
Name: apb_cfg_initiator

Overview:
- APB requester that drives the accelerator's `apb_interface` configuration bus from a simple command stream.
- Used by test benches and by the Vivado harness to program matrix dimensions, base addresses and the start bit of the multiplier top.
- Buffers commands in a small FIFO and issues them as standard APB SETUP/ACCESS transfers.
- Returns one response per command, carrying read data and an error flag.

Parameters:
- ADDR_W, 12, APB address width (`paddr`, `cmd_addr`).
- DATA_W, 32, APB data width (`pwdata`, `prdata`, `cmd_wdata`, `rsp_rdata`).
- FIFO_DEPTH, 4, command FIFO entries; power of 2, at least 2.
- TIMEOUT_CYCLES, 64, ACCESS-phase wait limit; used only with `APB_TIMEOUT_EN`.

Ports:
- clk  in  1  single clock; everything is rising-edge.
- reset  in  1  synchronous, active-high reset.
- cmd_valid  in  1  command present.
- cmd_ready  out  1  FIFO can accept; equals !full.
- cmd_write  in  1  1 = write, 0 = read.
- cmd_addr  in  ADDR_W  register address.
- cmd_wdata  in  DATA_W  write data; ignored for reads.
- rsp_valid  out  1  one-cycle pulse, one per completed command.
- rsp_rdata  out  DATA_W  captured `prdata`; 0 for writes.
- rsp_err  out  1  `pslverr` (or timeout) for this response.
- busy  out  1  FIFO non-empty or a transfer in flight.
- paddr  out  ADDR_W  APB address.
- psel  out  1  APB select.
- penable  out  1  APB enable.
- pwrite  out  1  APB direction.
- pwdata  out  DATA_W  APB write data.
- prdata  in  DATA_W  APB read data.
- pready  in  1  APB completer ready.
- pslverr  in  1  APB completer error.

Behaviour:
- Interface: one clock `clk`; reset `reset` is synchronous and active-high.
- Reset values: every output is 0 except `cmd_ready`, which is 1. Reset flushes the FIFO, forces state to IDLE and clears the timeout counter.
- Push: a command is pushed on an edge where `cmd_valid && cmd_ready`.
- `cmd_ready` depends only on FIFO occupancy. When the FIFO is full it stays low, even if a pop happens in the same cycle (no pass-through). Push and pop in the same cycle are both performed, and the count is unchanged.
- FSM states: IDLE, SETUP, ACCESS.
- IDLE:
  - Holds `psel = 0` and `penable = 0`.
  - If the FIFO is non-empty, pop the head and register `paddr`, `pwrite` and `pwdata` (`pwdata` = 0 for reads).
  - Then go to SETUP: next cycle `psel = 1`, `penable = 0`.
- SETUP: unconditionally go to ACCESS (`psel = 1`, `penable = 1`). `paddr`, `pwrite` and `pwdata` are held stable.
- ACCESS:
  - While `pready` = 0: hold every APB output stable.
  - On an edge with `pready` = 1:
    - Capture `prdata` (reads) and `pslverr`.
    - Next cycle assert `rsp_valid` with `rsp_rdata` and `rsp_err`.
    - If the FIFO is non-empty, pop the next entry and go directly to SETUP (back-to-back: `psel` stays 1, `penable` drops to 0). Otherwise go to IDLE.
- Latency:
  - Command accepted at edge E0 with the FIFO empty and idle: SETUP cycle follows E1, ACCESS follows E2.
  - With `pready` tied high, `rsp_valid` is high in the cycle after E3.
  - Back-to-back commands complete one every 2 cycles.
- Responses: issued in command order. There is no response backpressure; the consumer must sample `rsp_valid` every cycle.
- `pslverr` is sampled only in ACCESS with `pready` = 1 and is ignored at all other times.
- `busy` = FIFO non-empty OR state != IDLE OR response pending.
- Reset mid-transfer: on the reset edge, `psel` and `penable` drop, the in-flight command is discarded and no `rsp_valid` is produced for it or for any queued entry.
- FIFO pointers: log2(FIFO_DEPTH) bits plus one wrap bit.
  - full: indexes equal, wrap bits differ.
  - empty: indexes and wrap bits both equal.

Optional Feature:
- Macro: `APB_TIMEOUT_EN`.
- Defined:
  - A counter starts at 0 on entry to ACCESS and increments each cycle that `pready` = 0.
  - When it reaches TIMEOUT_CYCLES with `pready` still 0, the transfer is abandoned:
    - `psel` and `penable` drop.
    - A response is issued with `rsp_err` = 1 and `rsp_rdata` = 0.
    - The FSM continues with the next FIFO entry or goes to IDLE.
  - `pready` = 1 on the limit cycle counts as normal completion.
- Undefined: no counter exists and ACCESS waits indefinitely for `pready`.

Test Plan:
- Single write, `cmd_addr` = 0x010, `cmd_wdata` = 0x0000_0010, `pready` tied 1 → SETUP then ACCESS with `paddr` = 0x010, `pwrite` = 1, `pwdata` = 0x10; `rsp_valid` 3 cycles after accept with `rsp_err` = 0 and `rsp_rdata` = 0.
- Read with 3 wait states, `prdata` = 0xDEAD_BEEF → outputs stable for 4 ACCESS cycles; `rsp_rdata` = 0xDEADBEEF.
- Push 5 writes back-to-back into the empty FIFO with `pready` = 0 → `cmd_ready` low after 4 accepted pushes plus 1 popped into the transfer; releasing `pready` drains all 5 in order with 2-cycle spacing and 5 `rsp_valid` pulses.
- `pslverr` = 1 on the second of three reads → `rsp_err` pattern 0, 1, 0; the FSM does not stall.
- Assert `reset` during ACCESS with 2 entries queued → `psel` = 0 next cycle, no `rsp_valid`, `busy` = 0, `cmd_ready` = 1.
- `APB_TIMEOUT_EN` defined, TIMEOUT_CYCLES = 8, `pready` held 0 → transfer abandoned after 8 wait cycles; `rsp_err` = 1 and `rsp_rdata` = 0; the next queued command then proceeds normally.
